// File: rtl/fft8_bf_scheduler.sv
// Butterfly scheduler for an in-place radix-2 DIT 8-point FFT sharing one butterfly unit.
// Optional inverse-transform control ports are enabled with `define FFT_INVERSE_EN.
module fft8_bf_scheduler #(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_clear,
`ifdef FFT_INVERSE_EN
  input  logic       i_inverse,
  output logic       o_tw_conj,
`endif
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_stage,
  output logic       o_rd_en,
  output logic [2:0] o_rd_addr_a,
  output logic [2:0] o_rd_addr_b,
  output logic [1:0] o_tw_idx,
  output logic       o_wr_en,
  output logic [2:0] o_wr_addr_a,
  output logic [2:0] o_wr_addr_b
);

  localparam int         LAT       = RD_LAT + BF_LAT;
  localparam logic [2:0] WAIT_LOAD = 3'(LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_FIN} state_t;

  state_t     r_state;
  logic [1:0] r_stage, r_bf;
  logic [2:0] r_cnt;
  logic       r_busy, r_done, r_rd_en, r_wr_en, r_conj;
  logic [2:0] r_rd_a, r_rd_b, r_wr_a, r_wr_b;
  logic [1:0] r_tw;

  logic [1:0] w_nxt_stage, w_nxt_bf, w_nxt_tw;
  logic [2:0] w_nxt_a, w_nxt_b;

  // Indices and addresses of the butterfly that the next ISSUE will launch.
  always_comb begin
    w_nxt_stage = r_stage;
    w_nxt_bf    = r_bf + 2'd1;
    if (r_state == S_IDLE) begin
      w_nxt_stage = 2'd0;
      w_nxt_bf    = 2'd0;
    end else if (r_bf == 2'd3) begin
      w_nxt_stage = r_stage + 2'd1;
    end
    case (w_nxt_stage)
      2'd0: begin
        w_nxt_a  = {w_nxt_bf, 1'b0};
        w_nxt_tw = 2'd0;
      end
      2'd1: begin
        w_nxt_a  = {w_nxt_bf[1], 1'b0, w_nxt_bf[0]};
        w_nxt_tw = {w_nxt_bf[0], 1'b0};
      end
      default: begin
        w_nxt_a  = {1'b0, w_nxt_bf};
        w_nxt_tw = w_nxt_bf;
      end
    endcase
    w_nxt_b = w_nxt_a + (3'd1 << w_nxt_stage);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_bf    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_conj  <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_wr_a  <= '0;
      r_wr_b  <= '0;
      r_tw    <= '0;
    end else if (i_clear) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_bf    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_conj  <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_wr_a  <= '0;
      r_wr_b  <= '0;
      r_tw    <= '0;
    end else begin
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_ISSUE;
            r_stage <= w_nxt_stage;
            r_bf    <= w_nxt_bf;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b1;
            r_rd_a  <= w_nxt_a;
            r_rd_b  <= w_nxt_b;
            r_tw    <= w_nxt_tw;
`ifdef FFT_INVERSE_EN
            r_conj  <= i_inverse;
`endif
          end
        end
        S_ISSUE: begin
          if (LAT > 1) begin
            r_state <= S_WAIT;
            r_cnt   <= WAIT_LOAD;
          end else begin
            r_state <= S_WRITE;
            r_wr_en <= 1'b1;
            r_wr_a  <= r_rd_a;
            r_wr_b  <= r_rd_b;
          end
        end
        S_WAIT: begin
          // Leaving on cnt==1 lands WRITE exactly LAT cycles after ISSUE.
          if (r_cnt <= 3'd1) begin
            r_state <= S_WRITE;
            r_cnt   <= '0;
            r_wr_en <= 1'b1;
            r_wr_a  <= r_rd_a;
            r_wr_b  <= r_rd_b;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_WRITE: begin
          if (r_stage == 2'd2 && r_bf == 2'd3) begin
            r_state <= S_FIN;
          end else begin
            r_state <= S_ISSUE;
            r_stage <= w_nxt_stage;
            r_bf    <= w_nxt_bf;
            r_rd_en <= 1'b1;
            r_rd_a  <= w_nxt_a;
            r_rd_b  <= w_nxt_b;
            r_tw    <= w_nxt_tw;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_conj  <= 1'b0;
          r_stage <= '0;
          r_bf    <= '0;
          r_tw    <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_stage     = r_stage;
  assign o_rd_en     = r_rd_en;
  assign o_rd_addr_a = r_rd_a;
  assign o_rd_addr_b = r_rd_b;
  assign o_tw_idx    = r_tw;
  assign o_wr_en     = r_wr_en;
  assign o_wr_addr_a = r_wr_a;
  assign o_wr_addr_b = r_wr_b;
`ifdef FFT_INVERSE_EN
  assign o_tw_conj   = r_conj;
`else
  logic w_conj_unused;
  assign w_conj_unused = r_conj;
`endif

endmodule

// File: tb/tb_fft8_bf_scheduler.sv
// Directed bench for fft8_bf_scheduler: butterfly order/addresses/twiddles, latency and
// start/clear/reset corner cases, plus an RD_LAT=3/BF_LAT=0 instance for timing.
module tb_fft8_bf_scheduler;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_start = 1'b0, i_clear = 1'b0, i_start3 = 1'b0;
  logic o_busy, o_done, o_rd_en, o_wr_en;
  logic [1:0] o_stage, o_tw_idx;
  logic [2:0] o_rd_addr_a, o_rd_addr_b, o_wr_addr_a, o_wr_addr_b;
  logic busy3, done3, rd_en3, wr_en3;
  logic [1:0] stage3, tw3;
  logic [2:0] rda3, rdb3, wra3, wrb3;
`ifdef FFT_INVERSE_EN
  logic i_inverse = 1'b0;
  logic o_tw_conj, conj3;
`endif

  always #5 i_clk = ~i_clk;

  fft8_bf_scheduler #(.RD_LAT(1), .BF_LAT(1)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_clear(i_clear),
`ifdef FFT_INVERSE_EN
    .i_inverse(i_inverse), .o_tw_conj(o_tw_conj),
`endif
    .o_busy(o_busy), .o_done(o_done), .o_stage(o_stage), .o_rd_en(o_rd_en),
    .o_rd_addr_a(o_rd_addr_a), .o_rd_addr_b(o_rd_addr_b), .o_tw_idx(o_tw_idx),
    .o_wr_en(o_wr_en), .o_wr_addr_a(o_wr_addr_a), .o_wr_addr_b(o_wr_addr_b));

  fft8_bf_scheduler #(.RD_LAT(3), .BF_LAT(0)) u_dut3 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start3), .i_clear(1'b0),
`ifdef FFT_INVERSE_EN
    .i_inverse(1'b0), .o_tw_conj(conj3),
`endif
    .o_busy(busy3), .o_done(done3), .o_stage(stage3), .o_rd_en(rd_en3),
    .o_rd_addr_a(rda3), .o_rd_addr_b(rdb3), .o_tw_idx(tw3),
    .o_wr_en(wr_en3), .o_wr_addr_a(wra3), .o_wr_addr_b(wrb3));

  logic [18:0] outs, outs3;
  assign outs  = {o_busy, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_idx,
                  o_wr_en, o_wr_addr_a, o_wr_addr_b};
  assign outs3 = {busy3, done3, stage3, rd_en3, rda3, rdb3, tw3, wr_en3, wra3, wrb3};

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Event monitor for the default-latency instance.
  logic mon_clr = 1'b1;
  int nrd, nwr, ndone;
  int rd_cyc[16], wr_cyc[16];
  logic [2:0] rd_a[16], rd_b[16], wr_a[16], wr_b[16];
  logic [1:0] rd_tw[16], rd_stg[16], wr_tw[16];
  always @(negedge i_clk) begin
    if (mon_clr) begin
      nrd = 0; nwr = 0; ndone = 0;
    end else begin
      if (o_rd_en && nrd < 16) begin
        rd_cyc[nrd] = cyc; rd_a[nrd] = o_rd_addr_a; rd_b[nrd] = o_rd_addr_b;
        rd_tw[nrd] = o_tw_idx; rd_stg[nrd] = o_stage; nrd++;
      end
      if (o_wr_en && nwr < 16) begin
        wr_cyc[nwr] = cyc; wr_a[nwr] = o_wr_addr_a; wr_b[nwr] = o_wr_addr_b;
        wr_tw[nwr] = o_tw_idx; nwr++;
      end
      if (o_done) ndone++;
    end
  end

  typedef struct {
    logic [1:0] stg;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
  } vec_t;
  vec_t vt[12];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic pulse_start(output int t0);
    @(posedge i_clk);
    #1 i_start = 1'b1;
    t0 = cyc;
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int dc);
    dc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge i_clk);
      if (o_done) begin
        dc = cyc;
        break;
      end
    end
  endtask

  task automatic clear_mon();
    @(negedge i_clk);
    mon_clr = 1'b1;
    @(negedge i_clk);
    mon_clr = 1'b0;
  endtask

  initial begin
    int t0, dc, r3, w3;
    vt[0]  = '{2'd0, 3'd0, 3'd1, 2'd0}; vt[1]  = '{2'd0, 3'd2, 3'd3, 2'd0};
    vt[2]  = '{2'd0, 3'd4, 3'd5, 2'd0}; vt[3]  = '{2'd0, 3'd6, 3'd7, 2'd0};
    vt[4]  = '{2'd1, 3'd0, 3'd2, 2'd0}; vt[5]  = '{2'd1, 3'd1, 3'd3, 2'd2};
    vt[6]  = '{2'd1, 3'd4, 3'd6, 2'd0}; vt[7]  = '{2'd1, 3'd5, 3'd7, 2'd2};
    vt[8]  = '{2'd2, 3'd0, 3'd4, 2'd0}; vt[9]  = '{2'd2, 3'd1, 3'd5, 2'd1};
    vt[10] = '{2'd2, 3'd2, 3'd6, 2'd2}; vt[11] = '{2'd2, 3'd3, 3'd7, 2'd3};

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("reset_outs", int'(outs), 0);
    chk("reset_outs3", int'(outs3), 0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("idle_outs", int'(outs), 0);

    // Full forward run, table-driven check of every butterfly
    clear_mon();
    pulse_start(t0);
    wait_done(60, dc);
    chk("done_latency", dc - t0, 38);
    @(negedge i_clk);
    chk("busy_after_done", int'(o_busy), 0);
    chk("n_reads", nrd, 12);
    chk("n_writes", nwr, 12);
    chk("n_done", ndone, 1);
    for (int i = 0; i < 12 && i < nrd && i < nwr; i++) begin
      chk($sformatf("rd_cyc[%0d]", i), rd_cyc[i] - t0, 1 + 3 * i);
      chk($sformatf("rd_stage[%0d]", i), int'(rd_stg[i]), int'(vt[i].stg));
      chk($sformatf("rd_a[%0d]", i), int'(rd_a[i]), int'(vt[i].a));
      chk($sformatf("rd_b[%0d]", i), int'(rd_b[i]), int'(vt[i].b));
      chk($sformatf("rd_tw[%0d]", i), int'(rd_tw[i]), int'(vt[i].tw));
      chk($sformatf("wr_delay[%0d]", i), wr_cyc[i] - rd_cyc[i], 2);
      chk($sformatf("wr_a[%0d]", i), int'(wr_a[i]), int'(vt[i].a));
      chk($sformatf("wr_b[%0d]", i), int'(wr_b[i]), int'(vt[i].b));
      chk($sformatf("wr_tw_held[%0d]", i), int'(wr_tw[i]), int'(vt[i].tw));
    end

    // i_start re-pulsed mid-run is ignored
    clear_mon();
    pulse_start(t0);
    @(negedge i_clk);
    chk("busy_after_start", int'(o_busy), 1);
    goto_cycle(t0 + 10);
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    wait_done(60, dc);
    chk("repulse_done_latency", dc - t0, 38);
    repeat (3) @(negedge i_clk);
    chk("repulse_n_done", ndone, 1);
    chk("repulse_n_reads", nrd, 12);

    // i_clear mid-run aborts without o_done
    clear_mon();
    pulse_start(t0);
    goto_cycle(t0 + 20);
    i_clear = 1'b1;
    @(posedge i_clk);
    #1 i_clear = 1'b0;
    @(negedge i_clk);
    chk("clear_cycle", cyc - t0, 21);
    chk("clear_outs", int'(outs), 0);
    wait_done(45, dc);
    chk("clear_no_done", dc, -1);
    chk("clear_n_done", ndone, 0);
    pulse_start(t0);
    wait_done(60, dc);
    chk("after_clear_latency", dc - t0, 38);

    // start and clear together in IDLE: clear wins
    @(posedge i_clk);
    #1 begin i_start = 1'b1; i_clear = 1'b1; end
    @(posedge i_clk);
    #1 begin i_start = 1'b0; i_clear = 1'b0; end
    @(negedge i_clk);
    chk("start_clear_busy", int'(o_busy), 0);
    chk("start_clear_rd", int'(o_rd_en), 0);

    // Asynchronous reset mid-run
    clear_mon();
`ifdef FFT_INVERSE_EN
    i_inverse = 1'b1;
`endif
    pulse_start(t0);
`ifdef FFT_INVERSE_EN
    i_inverse = 1'b0;
`endif
    goto_cycle(t0 + 15);
`ifdef FFT_INVERSE_EN
    chk("tw_conj_run", int'(o_tw_conj), 1);
`endif
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst_outs", int'(outs), 0);
    chk("async_rst_busy", int'(o_busy), 0);
`ifdef FFT_INVERSE_EN
    chk("tw_conj_rst", int'(o_tw_conj), 0);
`endif
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    wait_done(45, dc);
    chk("rst_no_done", dc, -1);

    // RD_LAT=3, BF_LAT=0 instance
    @(posedge i_clk);
    #1 i_start3 = 1'b1;
    t0 = cyc;
    @(posedge i_clk);
    #1 i_start3 = 1'b0;
    dc = -1; r3 = -1; w3 = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge i_clk);
      if (rd_en3 && r3 < 0) r3 = cyc;
      if (wr_en3 && w3 < 0) w3 = cyc;
      if (done3) begin
        dc = cyc;
        break;
      end
    end
    chk("lat3_first_rd", r3 - t0, 1);
    chk("lat3_wr_delay", w3 - r3, 3);
    chk("lat3_done_latency", dc - t0, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
